// File: rtl/int_seq_pkg.sv
// Shared CPU definitions used by the interrupt entry sequencer: state encoding,
// flag-controller select codes, fixed vector types and flag bit positions.
package int_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INTA,
        ST_PUSHF,
        ST_CLRF,
        ST_PUSHCS,
        ST_PUSHIP,
        ST_RDIP,
        ST_RDCS,
        ST_DONE
    } state_t;

    localparam logic [4:0] FS_LOADALL = 5'd30;
    localparam logic [4:0] FS_NOP     = 5'd31;

    localparam logic [7:0] TYPE_DIV  = 8'd0;
    localparam logic [7:0] TYPE_STEP = 8'd1;
    localparam logic [7:0] TYPE_NMI  = 8'd2;

    localparam int IF_BIT = 9;
    localparam int TF_BIT = 8;

    // Flag word with IF and TF cleared, everything else preserved.
    localparam logic [15:0] FLAG_CLR_MASK = 16'hFCFF;

    // Vector table entry: 4 bytes per type, IP word first then CS word.
    function automatic logic [15:0] vec_offset(input logic [15:0] base,
                                               input logic [7:0]  vtype,
                                               input logic        cs_word);
        return base + {6'd0, vtype, 2'b00} + (cs_word ? 16'd2 : 16'd0);
    endfunction

endpackage

// File: rtl/int_seq_prio.sv
// Picks the winning interrupt source at an instruction boundary and keeps the
// NMI edge latch so an NMI seen during a busy sequence is not lost.
module int_seq_prio
    import int_seq_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst,
    input  logic       div_err,
    input  logic       sw_int,
    input  logic [7:0] sw_type,
    input  logic       nmi,
    input  logic       intr,
    input  logic       if_flag,
    input  logic       tf_flag,
    input  logic       nmi_clr,
    output logic       sel_valid,
    output logic [7:0] sel_type,
    output logic       sel_inta,
    output logic       sel_nmi
);

    logic nmi_prev_reg;
    logic nmi_pending_reg;

    // A fresh edge wins over a same-cycle clear so no NMI is dropped.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            nmi_prev_reg    <= 1'b0;
            nmi_pending_reg <= 1'b0;
        end else begin
            nmi_prev_reg    <= nmi;
            nmi_pending_reg <= (nmi_pending_reg && !nmi_clr) || (nmi && !nmi_prev_reg);
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_type  = 8'd0;
        sel_inta  = 1'b0;
        sel_nmi   = 1'b0;
        if (div_err) begin
            sel_valid = 1'b1;
            sel_type  = TYPE_DIV;
        end else if (sw_int) begin
            sel_valid = 1'b1;
            sel_type  = sw_type;
        end else if (nmi_pending_reg) begin
            sel_valid = 1'b1;
            sel_type  = TYPE_NMI;
            sel_nmi   = 1'b1;
        end else if (intr && if_flag) begin
            sel_valid = 1'b1;
            sel_inta  = 1'b1;
        end else if (tf_flag) begin
            sel_valid = 1'b1;
            sel_type  = TYPE_STEP;
        end
    end

endmodule

// File: rtl/int_seq.sv
// Interrupt entry sequencer: pushes FLAGS/CS/IP, clears IF/TF through the flag
// controller, reads the new IP:CS from the vector table and strobes the load.
module int_seq
    import int_seq_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = 16'h0000,
    parameter logic [4:0]  NOP_FSEL = FS_NOP
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iInstrEnd,
    input  logic [15:0] iFlgWrd,
    input  logic        iDivErr,
    input  logic        iSwInt,
    input  logic [7:0]  iSwType,
    input  logic        iNMI,
    input  logic        iINTR,
    input  logic        iIntVecValid,
    input  logic [7:0]  iIntVec,
    input  logic [15:0] iCS,
    input  logic [15:0] iIP,
    input  logic        iPushAck,
    input  logic        iRdAck,
    input  logic [15:0] iRdData,
    output logic        oINTA,
    output logic        oPushReq,
    output logic [15:0] oPushData,
    output logic        oRdReq,
    output logic [15:0] oRdAddr,
    output logic [4:0]  oFSel,
    output logic [15:0] oFlagWrd,
    output logic [15:0] oNewIP,
    output logic [15:0] oNewCS,
    output logic        oLoad,
    output logic        oBusy
);

    state_t      state_reg;
    logic [7:0]  type_reg;
    logic [15:0] flags_reg;

    logic        sel_valid;
    logic [7:0]  sel_type;
    logic        sel_inta;
    logic        sel_nmi;
    logic        start;

    assign start = (state_reg == ST_IDLE) && iInstrEnd && sel_valid;

    int_seq_prio u_prio (
        .iClk     (iClk),
        .iRst     (iRst),
        .div_err  (iDivErr),
        .sw_int   (iSwInt),
        .sw_type  (iSwType),
        .nmi      (iNMI),
        .intr     (iINTR),
        .if_flag  (iFlgWrd[IF_BIT]),
        .tf_flag  (iFlgWrd[TF_BIT]),
        .nmi_clr  (start && sel_nmi),
        .sel_valid(sel_valid),
        .sel_type (sel_type),
        .sel_inta (sel_inta),
        .sel_nmi  (sel_nmi)
    );

    // Outputs are set on the edge that enters each state, so request data and
    // addresses stay frozen for as long as the matching ack is withheld.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg <= ST_IDLE;
            type_reg  <= 8'd0;
            flags_reg <= 16'd0;
            oINTA     <= 1'b0;
            oPushReq  <= 1'b0;
            oPushData <= 16'd0;
            oRdReq    <= 1'b0;
            oRdAddr   <= 16'd0;
            oFSel     <= NOP_FSEL;
            oFlagWrd  <= 16'd0;
            oNewIP    <= 16'd0;
            oNewCS    <= 16'd0;
            oLoad     <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            oLoad <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        type_reg  <= sel_type;
                        flags_reg <= iFlgWrd;
                        oBusy     <= 1'b1;
                        if (sel_inta) begin
                            state_reg <= ST_INTA;
                            oINTA     <= 1'b1;
                        end else begin
                            state_reg <= ST_PUSHF;
                            oPushReq  <= 1'b1;
                            oPushData <= iFlgWrd;
                        end
                    end
                end
                ST_INTA: begin
                    if (iIntVecValid) begin
                        state_reg <= ST_PUSHF;
                        type_reg  <= iIntVec;
                        oINTA     <= 1'b0;
                        oPushReq  <= 1'b1;
                        oPushData <= flags_reg;
                    end
                end
                ST_PUSHF: begin
                    if (iPushAck) begin
                        state_reg <= ST_CLRF;
                        oPushReq  <= 1'b0;
                        oFSel     <= FS_LOADALL;
                        oFlagWrd  <= flags_reg & FLAG_CLR_MASK;
                    end
                end
                ST_CLRF: begin
                    state_reg <= ST_PUSHCS;
                    oFSel     <= NOP_FSEL;
                    oFlagWrd  <= 16'd0;
                    oPushReq  <= 1'b1;
                    oPushData <= iCS;
                end
                ST_PUSHCS: begin
                    if (iPushAck) begin
                        state_reg <= ST_PUSHIP;
                        oPushData <= iIP;
                    end
                end
                ST_PUSHIP: begin
                    if (iPushAck) begin
                        state_reg <= ST_RDIP;
                        oPushReq  <= 1'b0;
                        oRdReq    <= 1'b1;
                        oRdAddr   <= vec_offset(VEC_BASE, type_reg, 1'b0);
                    end
                end
                ST_RDIP: begin
                    if (iRdAck) begin
                        state_reg <= ST_RDCS;
                        oNewIP    <= iRdData;
                        oRdAddr   <= vec_offset(VEC_BASE, type_reg, 1'b1);
                    end
                end
                ST_RDCS: begin
                    if (iRdAck) begin
                        state_reg <= ST_DONE;
                        oNewCS    <= iRdData;
                        oRdReq    <= 1'b0;
                        oLoad     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    oBusy     <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    oBusy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_seq.sv
// Self-checking bench for int_seq: ack/vector responders plus a behavioural
// model of source priority, stack contents, vector addresses and latency.
module tb_int_seq;

    localparam logic [15:0] VEC_BASE = 16'h0000;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iInstrEnd = 1'b0;
    logic [15:0] iFlgWrd = 16'd0;
    logic        iDivErr = 1'b0;
    logic        iSwInt = 1'b0;
    logic [7:0]  iSwType = 8'd0;
    logic        iNMI = 1'b0;
    logic        iINTR = 1'b0;
    logic        iIntVecValid = 1'b0;
    logic [7:0]  iIntVec = 8'd0;
    logic [15:0] iCS = 16'd0;
    logic [15:0] iIP = 16'd0;
    logic        iPushAck = 1'b0;
    logic        iRdAck = 1'b0;
    logic [15:0] iRdData = 16'd0;

    logic        oINTA, oPushReq, oRdReq, oLoad, oBusy;
    logic [15:0] oPushData, oRdAddr, oFlagWrd, oNewIP, oNewCS;
    logic [4:0]  oFSel;

    int_seq #(.VEC_BASE(VEC_BASE), .NOP_FSEL(5'd31)) dut (
        .iClk(iClk), .iRst(iRst), .iInstrEnd(iInstrEnd), .iFlgWrd(iFlgWrd),
        .iDivErr(iDivErr), .iSwInt(iSwInt), .iSwType(iSwType), .iNMI(iNMI),
        .iINTR(iINTR), .iIntVecValid(iIntVecValid), .iIntVec(iIntVec),
        .iCS(iCS), .iIP(iIP), .iPushAck(iPushAck), .iRdAck(iRdAck),
        .iRdData(iRdData), .oINTA(oINTA), .oPushReq(oPushReq),
        .oPushData(oPushData), .oRdReq(oRdReq), .oRdAddr(oRdAddr),
        .oFSel(oFSel), .oFlagWrd(oFlagWrd), .oNewIP(oNewIP), .oNewCS(oNewCS),
        .oLoad(oLoad), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // Test-owned responder configuration and per-sequence snapshots
    int          push_delay [3] = '{0, 0, 0};
    int          rd_delay [2] = '{0, 0};
    int          inta_delay = 0;
    logic [15:0] salt = 16'h0;
    int          s_pb = 0, s_rb = 0, s_ia = 0, s_cc = 0, s_ld = 0, s_un = 0, s_bf = 0;
    int          seq_lat, start_cyc, seq_no = 0;
    bit          seq_busy;
    bit          model_nmi = 1'b0;
    int          checks = 0, failures = 0;

    // Responder-owned observations
    logic [15:0] pushes_q [$];
    logic [15:0] reads_q [$];
    int          inta_cycles = 0, clrf_count = 0, bad_fsel = 0, unstable = 0;
    int          load_count = 0, load_cyc = 0;
    logic [15:0] clrf_word = 16'd0, load_ip = 16'd0, load_cs = 16'd0;
    int          push_wait = 0, rd_wait = 0, inta_wait = 0;
    logic [15:0] push_hold = 16'd0, rd_hold = 16'd0;

    // Stack, vector-table and interrupt-controller stand-ins, acting on the falling edge
    always @(negedge iClk) begin
        int pidx, ridx, pd, rd;
        pidx = pushes_q.size() - s_pb;
        ridx = reads_q.size() - s_rb;
        pd = (pidx >= 0 && pidx < 3) ? push_delay[pidx] : 0;
        rd = (ridx >= 0 && ridx < 2) ? rd_delay[ridx] : 0;
        if (oPushReq) begin
            if (push_wait == 0) push_hold = oPushData;
            else if (oPushData !== push_hold) unstable++;
            if (push_wait >= pd) begin
                iPushAck = 1'b1;
                pushes_q.push_back(oPushData);
                push_wait = 0;
            end else begin
                iPushAck = 1'b0;
                push_wait++;
            end
        end else begin
            iPushAck = 1'b0;
            push_wait = 0;
        end
        if (oRdReq) begin
            if (rd_wait == 0) rd_hold = oRdAddr;
            else if (oRdAddr !== rd_hold) unstable++;
            if (rd_wait >= rd) begin
                iRdAck = 1'b1;
                iRdData = oRdAddr ^ salt;
                reads_q.push_back(oRdAddr);
                rd_wait = 0;
            end else begin
                iRdAck = 1'b0;
                rd_wait++;
            end
        end else begin
            iRdAck = 1'b0;
            rd_wait = 0;
        end
        if (oINTA) begin
            inta_cycles++;
            iIntVecValid = (inta_wait >= inta_delay);
            if (inta_wait < inta_delay) inta_wait++;
        end else begin
            iIntVecValid = 1'b0;
            inta_wait = 0;
        end
        if (oFSel == 5'd30) begin
            clrf_count++;
            clrf_word = oFlagWrd;
        end else if (oFSel != 5'd31) begin
            bad_fsel++;
        end
        if (oLoad) begin
            load_count++;
            load_cyc = cyc;
            load_ip = oNewIP;
            load_cs = oNewCS;
        end
    end

    task automatic tick();
        @(negedge iClk);
        #1;
    endtask

    function automatic logic [15:0] obs_push(input int i);
        if (s_pb + i < pushes_q.size()) return pushes_q[s_pb + i];
        return 16'hxxxx;
    endfunction

    function automatic logic [15:0] obs_read(input int i);
        if (s_rb + i < reads_q.size()) return reads_q[s_rb + i];
        return 16'hxxxx;
    endfunction

    // Reference: winning vector type, or -1 when nothing is taken
    function automatic int exp_type(input logic [15:0] f, input logic div, input logic sw,
                                    input logic [7:0] swt, input logic nmi,
                                    input logic intr, input logic [7:0] vec);
        if (div) return 0;
        if (sw) return int'(swt);
        if (nmi) return 2;
        if (intr && f[9]) return int'(vec);
        if (f[8]) return 1;
        return -1;
    endfunction

    function automatic int exp_latency(input bit use_inta);
        return 7 + push_delay[0] + push_delay[1] + push_delay[2] + rd_delay[0] + rd_delay[1]
               + (use_inta ? 1 + inta_delay : 0);
    endfunction

    // Presents one instruction boundary and waits for any resulting sequence to end
    task automatic run_seq(input logic [15:0] flags, input logic div, input logic sw,
                           input logic [7:0] swt, input logic intr, input logic [7:0] vec,
                           input logic [15:0] cs, input logic [15:0] ip, input bit drop_intr);
        int n;
        s_pb = pushes_q.size(); s_rb = reads_q.size(); s_ia = inta_cycles;
        s_cc = clrf_count; s_ld = load_count; s_un = unstable; s_bf = bad_fsel;
        iFlgWrd = flags; iDivErr = div; iSwInt = sw; iSwType = swt;
        iINTR = intr; iIntVec = vec; iCS = cs; iIP = ip; iInstrEnd = 1'b1;
        start_cyc = cyc;
        seq_busy = 1'b0;
        tick();
        iInstrEnd = 1'b0; iDivErr = 1'b0; iSwInt = 1'b0; iFlgWrd = ~flags;
        if (drop_intr) iINTR = 1'b0;
        for (n = 0; n < 300; n++) begin
            if (oBusy) seq_busy = 1'b1;
            else if (seq_busy || n >= 3) break;
            tick();
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL seq_timeout busy=%0b cycles=%0d want_done_within=300", oBusy, n);
        end
        iINTR = 1'b0;
        seq_lat = (load_count != s_ld) ? load_cyc - start_cyc : -1;
        seq_no++;
        $display("seq %0d: busy=%0b pushes=%0d reads=%0d first_read=%h latency=%0d",
                 seq_no, seq_busy, pushes_q.size() - s_pb, reads_q.size() - s_rb,
                 obs_read(0), seq_lat);
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        repeat (3) tick();
        iRst = 1'b0;
        tick();
        checks++; if (oFSel !== 5'd31) begin failures++; $display("FAIL reset_fsel got=%0d want=31", oFSel); end
        checks++; if ({oBusy, oPushReq, oRdReq, oINTA, oLoad} !== 5'b0) begin failures++;
            $display("FAIL reset_ctrl got=%b want=00000", {oBusy, oPushReq, oRdReq, oINTA, oLoad}); end
        checks++; if ({oPushData, oRdAddr, oFlagWrd, oNewIP, oNewCS} !== 80'd0) begin failures++;
            $display("FAIL reset_data got=%h want=0", {oPushData, oRdAddr, oFlagWrd, oNewIP, oNewCS}); end
    endtask

    task automatic test_div_error();
        push_delay = '{0, 0, 0}; rd_delay = '{0, 0}; inta_delay = 0; salt = 16'h1357;
        run_seq(16'h4B53, 1'b1, 1'b0, 8'h00, 1'b1, 8'h55, 16'h1234, 16'h5678, 1'b0);
        checks++; if ({obs_push(0), obs_push(1), obs_push(2)} !== {16'h4B53, 16'h1234, 16'h5678}) begin failures++;
            $display("FAIL div_pushes got=%h %h %h want=4b53 1234 5678", obs_push(0), obs_push(1), obs_push(2)); end
        checks++; if ({obs_read(0), obs_read(1)} !== {16'h0000, 16'h0002}) begin failures++;
            $display("FAIL div_reads got=%h %h want=0000 0002", obs_read(0), obs_read(1)); end
        checks++; if (inta_cycles - s_ia != 0) begin failures++;
            $display("FAIL div_inta got=%0d want=0", inta_cycles - s_ia); end
        checks++; if (seq_lat != 7) begin failures++; $display("FAIL div_latency got=%0d want=7", seq_lat); end
        checks++; if ({load_ip, load_cs} !== {16'h0000 ^ salt, 16'h0002 ^ salt}) begin failures++;
            $display("FAIL div_newaddr got=%h:%h want=%h:%h", load_cs, load_ip, 16'h0002 ^ salt, salt); end
    endtask

    task automatic test_ext_intr();
        inta_delay = 3; salt = 16'hBEEF;
        run_seq(16'h03C5, 1'b0, 1'b0, 8'h00, 1'b1, 8'h08, 16'hF000, 16'h0100, 1'b1);
        checks++; if ({obs_read(0), obs_read(1)} !== {16'h0020, 16'h0022}) begin failures++;
            $display("FAIL intr_reads got=%h %h want=0020 0022", obs_read(0), obs_read(1)); end
        checks++; if (clrf_count - s_cc != 1 || clrf_word !== 16'h00C5) begin failures++;
            $display("FAIL intr_clrf got=%0d/%h want=1/00c5", clrf_count - s_cc, clrf_word); end
        checks++; if (inta_cycles - s_ia != 4) begin failures++;
            $display("FAIL intr_inta_cycles got=%0d want=4", inta_cycles - s_ia); end
        checks++; if (seq_lat != 11) begin failures++; $display("FAIL intr_latency got=%0d want=11", seq_lat); end
        checks++; if (bad_fsel != s_bf) begin failures++; $display("FAIL intr_fsel got=%0d want=0", bad_fsel - s_bf); end
        inta_delay = 0;
    endtask

    task automatic test_masked();
        run_seq(16'h00FF, 1'b0, 1'b0, 8'h00, 1'b1, 8'h09, 16'h1111, 16'h2222, 1'b0);
        checks++; if (seq_busy || pushes_q.size() != s_pb) begin failures++;
            $display("FAIL masked_idle busy=%0b pushes=%0d want=0/0", seq_busy, pushes_q.size() - s_pb); end
        run_seq(16'h0100, 1'b0, 1'b0, 8'h00, 1'b1, 8'h09, 16'h1111, 16'h2222, 1'b0);
        checks++; if ({obs_read(0), obs_read(1)} !== {16'h0004, 16'h0006}) begin failures++;
            $display("FAIL masked_trap_reads got=%h %h want=0004 0006", obs_read(0), obs_read(1)); end
        checks++; if (inta_cycles != s_ia) begin failures++;
            $display("FAIL masked_inta got=%0d want=0", inta_cycles - s_ia); end
    endtask

    task automatic test_nmi();
        fork
            run_seq(16'h0200, 1'b0, 1'b1, 8'h21, 1'b0, 8'h00, 16'hA000, 16'hB000, 1'b0);
            begin
                repeat (3) tick();
                iNMI = 1'b1;
                tick();
                iNMI = 1'b0;
                model_nmi = 1'b1;
            end
        join
        checks++; if ({obs_read(0), obs_read(1)} !== {16'h0084, 16'h0086}) begin failures++;
            $display("FAIL nmi_swint_reads got=%h %h want=0084 0086", obs_read(0), obs_read(1)); end
        // NMI outranks a maskable request that is also pending
        run_seq(16'h0200, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 16'hA000, 16'hB002, 1'b0);
        if (exp_type(16'h0200, 1'b0, 1'b0, 8'h00, model_nmi, 1'b1, 8'h40) == 2) model_nmi = 1'b0;
        checks++; if ({obs_read(0), obs_read(1)} !== {16'h0008, 16'h000A}) begin failures++;
            $display("FAIL nmi_reads got=%h %h want=0008 000a", obs_read(0), obs_read(1)); end
        checks++; if (inta_cycles != s_ia) begin failures++;
            $display("FAIL nmi_inta got=%0d want=0", inta_cycles - s_ia); end
        run_seq(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0, 16'h0, 1'b0);
        checks++; if (seq_busy != (exp_type(16'h0000, 1'b0, 1'b0, 8'h00, model_nmi, 1'b0, 8'h00) >= 0)) begin failures++;
            $display("FAIL nmi_cleared busy=%0b want=0", seq_busy); end
    endtask

    task automatic test_stall();
        push_delay = '{0, 4, 0};
        run_seq(16'h0001, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'hC0DE, 16'h7777, 1'b0);
        checks++; if (unstable != s_un) begin failures++;
            $display("FAIL stall_stable changes=%0d want=0", unstable - s_un); end
        checks++; if (obs_push(1) !== 16'hC0DE) begin failures++;
            $display("FAIL stall_cs got=%h want=c0de", obs_push(1)); end
        checks++; if (seq_lat != 11) begin failures++; $display("FAIL stall_latency got=%0d want=11", seq_lat); end
        push_delay = '{0, 0, 0};
    endtask

    task automatic test_reset_mid();
        int base_ld, base_rd;
        rd_delay = '{6, 0};
        base_ld = load_count;
        base_rd = reads_q.size();
        fork
            run_seq(16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1, 16'h2, 1'b0);
            begin
                for (int n = 0; n < 50 && !oRdReq; n++) tick();
                tick();
                iRst = 1'b1;
                tick();
                checks++; if ({oBusy, oPushReq, oRdReq, oINTA, oLoad, oFSel} !== {5'b0, 5'd31}) begin failures++;
                    $display("FAIL rstmid_ctrl got=%b want=0000011111", {oBusy, oPushReq, oRdReq, oINTA, oLoad, oFSel}); end
                checks++; if ({oPushData, oRdAddr, oFlagWrd, oNewIP, oNewCS} !== 80'd0) begin failures++;
                    $display("FAIL rstmid_data got=%h want=0", {oPushData, oRdAddr, oFlagWrd, oNewIP, oNewCS}); end
                iRst = 1'b0;
            end
        join
        repeat (10) tick();
        checks++; if (load_count != base_ld || reads_q.size() != base_rd || oPushReq || oRdReq) begin failures++;
            $display("FAIL rstmid_quiet loads=%0d reads=%0d req=%b%b want=0 0 00",
                     load_count - base_ld, reads_q.size() - base_rd, oPushReq, oRdReq); end
        rd_delay = '{0, 0};
    endtask

    task automatic test_random();
        logic [15:0] flags, cs, ip, a0;
        logic        div, sw, intr;
        logic [7:0]  swt, vec;
        int          et, lat;
        bit          use_inta;
        for (int n = 0; n < 12; n++) begin
            flags = 16'($urandom); cs = 16'($urandom); ip = 16'($urandom); salt = 16'($urandom);
            div = ($urandom_range(0, 5) == 0); sw = ($urandom_range(0, 3) == 0);
            swt = 8'($urandom); vec = 8'($urandom); intr = 1'($urandom_range(0, 1));
            push_delay = '{$urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2)};
            rd_delay = '{$urandom_range(0, 2), $urandom_range(0, 2)};
            inta_delay = $urandom_range(0, 2);
            et = exp_type(flags, div, sw, swt, model_nmi, intr, vec);
            use_inta = !div && !sw && !model_nmi && intr && flags[9];
            lat = exp_latency(use_inta);
            a0 = VEC_BASE + 16'(et * 4);
            run_seq(flags, div, sw, swt, intr, vec, cs, ip, 1'b0);
            checks++; if (seq_busy != (et >= 0)) begin failures++;
                $display("FAIL rnd%0d_taken got=%0b want=%0b", n, seq_busy, et >= 0); end
            if (et >= 0) begin
                checks++; if ({obs_push(0), obs_push(1), obs_push(2)} !== {flags, cs, ip}) begin failures++;
                    $display("FAIL rnd%0d_pushes got=%h %h %h want=%h %h %h", n,
                             obs_push(0), obs_push(1), obs_push(2), flags, cs, ip); end
                checks++; if ({obs_read(0), obs_read(1)} !== {a0, a0 + 16'd2}) begin failures++;
                    $display("FAIL rnd%0d_reads got=%h %h want=%h %h", n, obs_read(0), obs_read(1), a0, a0 + 16'd2); end
                checks++; if (seq_lat != lat) begin failures++;
                    $display("FAIL rnd%0d_latency got=%0d want=%0d", n, seq_lat, lat); end
                checks++; if ({oNewIP, oNewCS} !== {a0 ^ salt, (a0 + 16'd2) ^ salt}) begin failures++;
                    $display("FAIL rnd%0d_newaddr got=%h:%h want=%h:%h", n, oNewCS, oNewIP,
                             (a0 + 16'd2) ^ salt, a0 ^ salt); end
                checks++; if (clrf_word !== (flags & ~16'h0300) || clrf_count - s_cc != 1) begin failures++;
                    $display("FAIL rnd%0d_clrf got=%h want=%h", n, clrf_word, flags & ~16'h0300); end
                checks++; if (inta_cycles - s_ia != (use_inta ? inta_delay + 1 : 0)) begin failures++;
                    $display("FAIL rnd%0d_inta got=%0d want=%0d", n, inta_cycles - s_ia,
                             use_inta ? inta_delay + 1 : 0); end
            end
        end
        push_delay = '{0, 0, 0}; rd_delay = '{0, 0}; inta_delay = 0;
    endtask

    initial begin
        test_reset();
        test_div_error();
        test_ext_intr();
        test_masked();
        test_nmi();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
